// File: rtl/clock_pkg.sv
// Shared definitions for the 24 h clock: mode encodings
// and the set-controller state type (also used by the display).
package clock_pkg;

  localparam logic [1:0] MODE_RUN     = 2'd0;
  localparam logic [1:0] MODE_SET_HR  = 2'd1;
  localparam logic [1:0] MODE_SET_MIN = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN     = MODE_RUN,
    ST_SET_HR  = MODE_SET_HR,
    ST_SET_MIN = MODE_SET_MIN
  } state_e;

  function automatic logic is_set(state_e s);
    return s != ST_RUN;
  endfunction

endpackage

// File: rtl/time_set_ctrl_rise_detect.sv
// rise_detect: one-flop rising-edge detector for a synchronised level.
// Ports: clk, rst (async high), d (level in), rise (1-cycle pulse).
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: RUN/SET_HR/SET_MIN mode controller steering ticks
// into the sec/min/hr counters. In: clk_1Hz, rst, mode_btn, inc_btn,
// sec_tick_in, min_tick_in. Out: sec_en, sec_clr, min_tick, hr_tick,
// mode[1:0], blink.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_S = 10
) (
  input  logic       clk_1Hz,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       sec_tick_in,
  input  logic       min_tick_in,
  output logic       sec_en,
  output logic       sec_clr,
  output logic       min_tick,
  output logic       hr_tick,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int IW = $clog2(TIMEOUT_S + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_S - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT_S);

  state_e state, state_nx;

  logic          press;
  logic          in_set;
  logic          inc_act;
  logic          timeout;
  logic          enter_hr;
  logic          enter_min;
  logic          exit_set;
  logic          edited;
  logic          inc_lock;
  logic [IW-1:0] idle_cnt;

  rise_detect u_mode_rise (
    .clk  (clk_1Hz),
    .rst  (rst),
    .d    (mode_btn),
    .rise (press)
  );

  assign in_set  = is_set(state);
  // A mode press in the same cycle swallows the increment.
  assign inc_act = in_set & inc_btn & ~inc_lock & ~press;
  assign timeout = in_set & (idle_cnt == IDLE_LAST)
                 & ~press & ~inc_act;

  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_RUN: begin
        if (press) state_nx = ST_SET_HR;
      end
      ST_SET_HR: begin
        if (press)        state_nx = ST_SET_MIN;
        else if (timeout) state_nx = ST_RUN;
      end
      ST_SET_MIN: begin
        if (press | timeout) state_nx = ST_RUN;
      end
      default: state_nx = ST_RUN;
    endcase
  end

  assign enter_hr  = (state == ST_RUN) & press;
  assign enter_min = (state == ST_SET_HR) & press;
  assign exit_set  = in_set & (state_nx == ST_RUN);

  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      sec_clr  <= 1'b0;
      blink    <= 1'b0;
      edited   <= 1'b0;
      inc_lock <= 1'b0;
      idle_cnt <= '0;
    end else begin
      // Seconds restart from 0 only if the time was actually changed.
      sec_clr <= exit_set & edited;

      if (enter_hr | enter_min)    blink <= 1'b1;
      else if (in_set & ~exit_set) blink <= ~blink;
      else                         blink <= 1'b0;

      if (enter_hr)     edited <= 1'b0;
      else if (inc_act) edited <= 1'b1;

      // A button still held on entry must be released before it counts.
      if (enter_hr | enter_min) inc_lock <= inc_btn;
      else if (!inc_btn)        inc_lock <= 1'b0;

      if (enter_hr | enter_min | inc_act | ~in_set)
        idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX)
        idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_comb begin
    sec_en   = 1'b1;
    min_tick = sec_tick_in;
    hr_tick  = min_tick_in;
    case (state)
      ST_SET_HR: begin
        sec_en   = 1'b0;
        min_tick = 1'b0;
        hr_tick  = inc_act;
      end
      ST_SET_MIN: begin
        sec_en   = 1'b0;
        min_tick = inc_act;
        hr_tick  = 1'b0;
      end
      default: ;
    endcase
  end

  assign mode = state;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: vector table plus hand sequences,
// expected outputs queued on drive and compared mid-cycle.
module tb_time_set_ctrl;
  import clock_pkg::*;

  logic       clk_1Hz = 1'b0;
  logic       rst = 1'b1;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic       sec_tick_in = 1'b0;
  logic       min_tick_in = 1'b0;
  logic       sec_en;
  logic       sec_clr;
  logic       min_tick;
  logic       hr_tick;
  logic [1:0] mode;
  logic       blink;

  time_set_ctrl #(.TIMEOUT_S(10)) dut (
    .clk_1Hz     (clk_1Hz),
    .rst         (rst),
    .mode_btn    (mode_btn),
    .inc_btn     (inc_btn),
    .sec_tick_in (sec_tick_in),
    .min_tick_in (min_tick_in),
    .sec_en      (sec_en),
    .sec_clr     (sec_clr),
    .min_tick    (min_tick),
    .hr_tick     (hr_tick),
    .mode        (mode),
    .blink       (blink)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  typedef struct {
    logic       mb;
    logic       ib;
    logic       st;
    logic       mt;
    logic [6:0] exp;
    string      nm;
  } vec_t;

  vec_t       tbl[$];
  logic [6:0] sb_q[$];
  string      sb_nm[$];
  int         n_vec = 0;
  int         n_err = 0;

  // {sec_en, sec_clr, min_tick, hr_tick, mode, blink}
  function automatic logic [6:0] ex(
    logic en, logic clr, logic mn, logic hr,
    logic [1:0] md, logic bl);
    return {en, clr, mn, hr, md, bl};
  endfunction

  function automatic logic [6:0] run_ex(logic st, logic mt);
    return ex(1'b1, 1'b0, st, mt, MODE_RUN, 1'b0);
  endfunction

  task automatic add(input logic mb, input logic ib,
                     input logic st, input logic mt,
                     input logic [6:0] e, input string nm);
    vec_t v;
    v.mb = mb; v.ib = ib; v.st = st; v.mt = mt;
    v.exp = e; v.nm = nm;
    tbl.push_back(v);
  endtask

  task automatic check();
    logic [6:0] act;
    logic [6:0] e;
    string      nm;
    act = {sec_en, sec_clr, min_tick, hr_tick, mode, blink};
    e   = sb_q.pop_front();
    nm  = sb_nm.pop_front();
    n_vec++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (en,clr,min,hr,mode,blink)",
               nm, act, e);
    end
  endtask

  task automatic cyc(input logic mb, input logic ib,
                     input logic st, input logic mt,
                     input logic [6:0] e, input string nm);
    @(negedge clk_1Hz);
    mode_btn    = mb;
    inc_btn     = ib;
    sec_tick_in = st;
    min_tick_in = mt;
    sb_q.push_back(e);
    sb_nm.push_back(nm);
    #1 check();
  endtask

  initial begin
    logic st, mt;

    // T1: free run
    for (int i = 0; i < 120; i++) begin
      st = (i % 60 == 59);
      mt = (i == 100);
      add(0, 0, st, mt, run_ex(st, mt), "t1_run");
    end

    // T2: set hours, then walk back to RUN
    add(1, 0, 0, 0, run_ex(0, 0), "t2_press");
    for (int k = 0; k < 5; k++) begin
      mt = (k == 2);
      add(0, 1, 0, mt, ex(0, 0, 0, 1, MODE_SET_HR, k % 2 == 0),
          "t2_hr_inc");
    end
    add(0, 0, 0, 0, ex(0, 0, 0, 0, MODE_SET_HR, 0), "t2_release");
    add(1, 0, 0, 0, ex(0, 0, 0, 0, MODE_SET_HR, 1), "t2_to_min");
    add(0, 0, 1, 0, ex(0, 0, 0, 0, MODE_SET_MIN, 1), "t2_min");
    add(1, 0, 0, 0, ex(0, 0, 0, 0, MODE_SET_MIN, 0), "t2_to_run");
    add(0, 0, 0, 0, ex(1, 1, 0, 0, MODE_RUN, 0), "t2_sec_clr");
    add(0, 0, 0, 0, run_ex(0, 0), "t2_clr_once");

    // T3: 61 minute increments, no carry to hours
    add(1, 0, 0, 0, run_ex(0, 0), "t3_p1");
    add(0, 0, 0, 0, ex(0, 0, 0, 0, MODE_SET_HR, 1), "t3_r1");
    add(1, 0, 0, 0, ex(0, 0, 0, 0, MODE_SET_HR, 0), "t3_p2");
    for (int k = 0; k < 61; k++) begin
      st = (k % 10 == 3);
      mt = (k % 20 == 7);
      add(0, 1, st, mt, ex(0, 0, 1, 0, MODE_SET_MIN, k % 2 == 0),
          "t3_min_inc");
    end
    add(0, 0, 0, 0, ex(0, 0, 0, 0, MODE_SET_MIN, 0), "t3_release");
    add(1, 0, 0, 0, ex(0, 0, 0, 0, MODE_SET_MIN, 1), "t3_exit");
    add(0, 0, 0, 0, ex(1, 1, 0, 0, MODE_RUN, 0), "t3_sec_clr");
    add(0, 0, 1, 0, run_ex(1, 0), "t3_run_again");

    // T4: held inc locked on entry; press beats inc
    add(1, 1, 0, 0, run_ex(0, 0), "t4_enter_held");
    for (int k = 0; k < 3; k++)
      add(0, 1, 0, 0, ex(0, 0, 0, 0, MODE_SET_HR, k % 2 == 0),
          "t4_locked");
    add(0, 0, 0, 0, ex(0, 0, 0, 0, MODE_SET_HR, 0), "t4_release");
    add(0, 1, 0, 0, ex(0, 0, 0, 1, MODE_SET_HR, 1), "t4_resume");
    add(1, 1, 0, 0, ex(0, 0, 0, 0, MODE_SET_HR, 0), "t4_press_inc");
    add(0, 1, 0, 0, ex(0, 0, 0, 0, MODE_SET_MIN, 1), "t4_min_lock");
    add(0, 0, 0, 0, ex(0, 0, 0, 0, MODE_SET_MIN, 0), "t4_min_rel");
    add(1, 0, 0, 0, ex(0, 0, 0, 0, MODE_SET_MIN, 1), "t4_exit");
    add(0, 0, 0, 0, ex(1, 1, 0, 0, MODE_RUN, 0), "t4_sec_clr");

    // Reset state
    @(negedge clk_1Hz);
    sb_q.push_back(run_ex(0, 0));
    sb_nm.push_back("reset");
    #1 check();
    rst = 1'b0;

    foreach (tbl[i])
      cyc(tbl[i].mb, tbl[i].ib, tbl[i].st, tbl[i].mt,
          tbl[i].exp, tbl[i].nm);

    // T5a: idle timeout, nothing edited
    cyc(1, 0, 0, 0, run_ex(0, 0), "t5_enter");
    for (int k = 1; k <= 10; k++)
      cyc(0, 0, 0, 0, ex(0, 0, 0, 0, MODE_SET_HR, k % 2), "t5_idle");
    cyc(0, 0, 0, 0, run_ex(0, 0), "t5_timeout");
    cyc(0, 0, 0, 0, run_ex(0, 0), "t5_no_clr");

    // T5b: one increment, timeout 10 clocks later with sec_clr
    cyc(1, 0, 0, 0, run_ex(0, 0), "t5b_enter");
    cyc(0, 1, 0, 0, ex(0, 0, 0, 1, MODE_SET_HR, 1), "t5b_inc");
    for (int k = 2; k <= 11; k++)
      cyc(0, 0, 0, 0, ex(0, 0, 0, 0, MODE_SET_HR, k % 2), "t5b_idle");
    cyc(0, 0, 0, 0, ex(1, 1, 0, 0, MODE_RUN, 0), "t5b_clr");
    cyc(0, 0, 0, 0, run_ex(0, 0), "t5b_after");

    // T6: async reset mid-cycle in SET_MIN with blink=1
    cyc(1, 0, 0, 0, run_ex(0, 0), "t6_p1");
    cyc(0, 1, 0, 0, ex(0, 0, 0, 1, MODE_SET_HR, 1), "t6_inc");
    cyc(1, 0, 0, 0, ex(0, 0, 0, 0, MODE_SET_HR, 0), "t6_p2");
    cyc(0, 0, 0, 0, ex(0, 0, 0, 0, MODE_SET_MIN, 1), "t6_blink");
    #2 rst = 1'b1;
    sb_q.push_back(run_ex(0, 0));
    sb_nm.push_back("t6_async_rst");
    #1 check();
    @(negedge clk_1Hz);
    rst = 1'b0;
    cyc(0, 0, 0, 0, run_ex(0, 0), "t6_after_rst");
    cyc(0, 0, 1, 1, run_ex(1, 1), "t6_run_ok");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
